iob_cache_perf_regs: RTL and testbench
======================================

Name: iob_cache_perf_regs

Overview:
- Software-facing register front-end for the cache performance counters.
- Sits directly downstream of the cache control counter block: consumes its four DATA_W hit/miss counters and drives its reset_counters input.
- Provides atomic snapshots, sticky wrap flags, a total-access sum and a CTRL register, all over a valid/ready request / rvalid response port from the cache CSR decoder.

Parameters:
- DATA_W, 32, width of counters and of the data bus.
- ADDR_W, 3, word-address width of the register space (8 registers).
- VERSION, 16'h0001, constant returned at the VERSION register; zero-extended to DATA_W.

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  reset; one clock; reset is asynchronous and active-low
- read_hit_cnt_i  in  DATA_W  live counter
- read_miss_cnt_i  in  DATA_W  live counter
- write_hit_cnt_i  in  DATA_W  live counter
- write_miss_cnt_i  in  DATA_W  live counter
- reset_counters_o  out  1  one-cycle clear pulse to the counter block
- req_valid_i  in  1  request valid
- req_addr_i  in  ADDR_W  word address
- req_wen_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DATA_W  write data
- req_ready_o  out  1  request accepted when valid & ready
- rsp_valid_o  out  1  response valid, one cycle
- rsp_rdata_o  out  DATA_W  read data; 0 for write responses

Behaviour:
- Register map (word address):
  - 0 SNAP_RH, 1 SNAP_RM, 2 SNAP_WH, 3 SNAP_WM: RO snapshots.
  - 4 CTRL: WO. bit0 SNAP, bit1 RST_CNT, bit2 CLR_WRAP. Reads return 0.
  - 5 STATUS: RO. bits[3:0] = wrap flags {WM,WH,RM,RH}; bit4 = snap_valid; other bits 0.
  - 6 TOTAL: RO. Sum of the four snapshots, mod 2^DATA_W.
  - 7 VERSION: RO.
- Writes to RO addresses are ignored but still acknowledged.
- FSM states IDLE, RST, RESP.
  - IDLE: req_ready_o=1. On accept: read goes to RESP, with rsp_rdata registered at the accept edge. Write goes to RST if wdata bit1 is set at CTRL, else to RESP.
  - RST: reset_counters_o=1 for exactly this cycle; req_ready_o=0; next state RESP.
  - RESP: rsp_valid_o=1 for one cycle; req_ready_o=0; next state IDLE.
- Latency:
  - Read accepted at edge N: response in cycle N+1.
  - Write with RST_CNT: response in cycle N+2.
  - Maximum throughput: one request per 2 cycles.
- SNAP: at the accept edge, all four live counters are captured simultaneously and snap_valid is set to 1. Snapshots are not cleared by RST_CNT.
- SNAP and RST_CNT in the same write: the snapshot holds the pre-reset values and the counters are cleared afterwards.
- Wrap detection:
  - One prev_msb register per counter, updated every cycle.
  - A flag sets when prev_msb=1 and the current MSB=0.
  - In the RST cycle, prev_msb and all flags are cleared. This takes priority over set, so the counter drop to 0 is never flagged.
- CLR_WRAP: clears the flags at the accept edge. A wrap detected in the same cycle wins (flag stays set).
- TOTAL is computed combinationally from the snapshots and registered only into rsp_rdata_o.
- Reset values (arst_n_i low):
  - State IDLE; reset_counters_o=0; rsp_valid_o=0; rsp_rdata_o=0.
  - Snapshots 0; snap_valid 0; flags 0; prev_msb 0.
  - req_ready_o=1, decoded from IDLE.
- Reset asserted mid-transaction: the pending response and any pending RST pulse are dropped with no glitch on reset_counters_o.
- Unmapped bits or addresses: none exist with ADDR_W=3. If ADDR_W is larger, addresses above 7 read 0 and writes to them are ignored.

Decomposition:
- Package iob_cache_perf_pkg holds:
  - Register address constants (ADDR_SNAP_RH..ADDR_VERSION).
  - CTRL bit indices (CTRL_SNAP=0, CTRL_RST=1, CTRL_CLRW=2).
  - STATUS bit indices.
  - FSM state encoding (2 bits: IDLE=0, RST=1, RESP=2).
- Sub-module iob_cache_wrap_detect: the prev_msb register plus the sticky flag with clear/set priority. It is instantiated four times.

Test Plan:
- Counters 5/3/7/1 live; write CTRL=0x1; read addr 0..3 and 6 -> 5, 3, 7, 1, then TOTAL=16; STATUS bit4=1; each rsp_valid exactly 1 cycle after accept.
- Write CTRL=0x3 with read_hit_cnt_i=9 -> reset_counters_o high exactly 1 cycle (accept+1); rsp_valid at accept+2; SNAP_RH reads 9; no wrap flag set.
- Drive read_miss_cnt_i 0xFFFFFFFF then 0x00000000 -> STATUS=0x02; write CTRL=0x4 -> STATUS bits[3:0]=0.
- Wrap event in the same cycle as a CTRL=0x4 accept -> flag remains 1.
- Snapshots 0xFFFFFFFF, 1, 0, 0 -> TOTAL=0.
- Back-to-back req_valid held high -> req_ready_o low in RESP/RST, requests accepted every 2nd cycle. Pull arst_n_i low during RST -> reset_counters_o=0 immediately; state IDLE; no response issued.

Source files
------------

// File: rtl/iob_cache_perf_pkg.sv
// Purpose: shared constants for the cache performance-counter register front-end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package iob_cache_perf_pkg;

    // Word addresses of the register map
    localparam logic [2:0] ADDR_SNAP_RH = 3'd0;
    localparam logic [2:0] ADDR_SNAP_RM = 3'd1;
    localparam logic [2:0] ADDR_SNAP_WH = 3'd2;
    localparam logic [2:0] ADDR_SNAP_WM = 3'd3;
    localparam logic [2:0] ADDR_CTRL    = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;
    localparam logic [2:0] ADDR_TOTAL   = 3'd6;
    localparam logic [2:0] ADDR_VERSION = 3'd7;

    // CTRL bit indices
    localparam int CTRL_SNAP = 0;
    localparam int CTRL_RST  = 1;
    localparam int CTRL_CLRW = 2;

    // STATUS bit indices: wrap flags occupy [3:0] as {WM,WH,RM,RH}
    localparam int STAT_WRAP_LSB = 0;
    localparam int STAT_SNAP_VLD = 4;

    // Number of counters fed from the counter block
    localparam int N_CNT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/iob_cache_wrap_detect.sv
// Purpose: sticky wrap flag for one counter (MSB falling 1->0 between cycles).
// Latency: flag visible the cycle after the wrap edge.
// Backpressure: none; sampled every cycle.
// Ports: clk_i/arst_n_i clock and async active-low reset; msb_i live counter MSB;
//        rst_i counter-clear cycle (clears history and flag); clr_i software flag clear;
//        flag_o sticky wrap flag.
module iob_cache_wrap_detect (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic msb_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic flag_o
);

    logic prev_msb_q;
    logic wrap;

    assign wrap = prev_msb_q & ~msb_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            prev_msb_q <= 1'b0;
            flag_o     <= 1'b0;
        end else begin
            // Clearing history in the clear cycle keeps the counter's drop to 0
            // from looking like a wrap on the following edge.
            prev_msb_q <= rst_i ? 1'b0 : msb_i;
            if (rst_i) begin
                flag_o <= 1'b0;
            end else if (wrap) begin
                flag_o <= 1'b1;     // a wrap beats a simultaneous software clear
            end else if (clr_i) begin
                flag_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iob_cache_perf_regs.sv
// Purpose: CSR front-end for cache hit/miss counters: snapshots, wrap flags, total, CTRL.
// Latency: read response 1 cycle after accept; write with RST_CNT responds 2 cycles after.
// Backpressure: req_ready_o low while a response or counter-clear is pending (1 req / 2 cycles).
// Ports: clk_i/arst_n_i clock and async active-low reset; *_cnt_i live counters;
//        reset_counters_o one-cycle clear pulse; req_* request channel; rsp_* response channel.
module iob_cache_perf_regs
    import iob_cache_perf_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 3,
    parameter logic [15:0] VERSION = 16'h0001
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DATA_W-1:0] read_hit_cnt_i,
    input  logic [DATA_W-1:0] read_miss_cnt_i,
    input  logic [DATA_W-1:0] write_hit_cnt_i,
    input  logic [DATA_W-1:0] write_miss_cnt_i,
    output logic              reset_counters_o,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_wen_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o
);

    state_t            state_q, state_d;
    logic              accept;
    logic              addr_ok;
    logic [2:0]        reg_idx;
    logic              ctrl_wr;
    logic              do_snap, do_rst, do_clrw;
    logic [DATA_W-1:0] cnt    [N_CNT];
    logic [DATA_W-1:0] snap_q [N_CNT];
    logic              snap_vld_q;
    logic [N_CNT-1:0]  wrap_flags;
    logic [DATA_W-1:0] total;
    logic [DATA_W-1:0] rd_dat;
    logic              unused_wdata;

    assign cnt[0] = read_hit_cnt_i;
    assign cnt[1] = read_miss_cnt_i;
    assign cnt[2] = write_hit_cnt_i;
    assign cnt[3] = write_miss_cnt_i;

    assign reg_idx = req_addr_i[2:0];

    // Only the low 8 words are mapped; anything above reads 0 and ignores writes.
    generate
        if (ADDR_W > 3) begin : g_addr_hi
            assign addr_ok = ~|req_addr_i[ADDR_W-1:3];
        end else begin : g_addr_lo
            assign addr_ok = 1'b1;
        end
    endgenerate

    // Accept is decoded straight from the state register so the output
    // process below never feeds back into it.
    assign accept  = req_valid_i & (state_q == ST_IDLE);
    assign ctrl_wr = accept & req_wen_i & addr_ok & (reg_idx == ADDR_CTRL);
    assign do_snap = ctrl_wr & req_wdata_i[CTRL_SNAP];
    assign do_rst  = ctrl_wr & req_wdata_i[CTRL_RST];
    assign do_clrw = ctrl_wr & req_wdata_i[CTRL_CLRW];

    assign unused_wdata = ^req_wdata_i[DATA_W-1:3];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        req_ready_o      = 1'b0;
        reset_counters_o = 1'b0;
        rsp_valid_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (accept) begin
                    state_d = do_rst ? ST_RST : ST_RESP;
                end
            end
            ST_RST: begin
                reset_counters_o = 1'b1;
                state_d          = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- snapshots
    // Snapshot is taken at the accept edge, before the counters see the
    // clear pulse, so SNAP|RST_CNT preserves the pre-clear values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < N_CNT; i++) begin
                snap_q[i] <= '0;
            end
            snap_vld_q <= 1'b0;
        end else if (do_snap) begin
            for (int i = 0; i < N_CNT; i++) begin
                snap_q[i] <= cnt[i];
            end
            snap_vld_q <= 1'b1;
        end
    end

    // --------------------------------------------------------- wrap flags
    generate
        for (genvar i = 0; i < N_CNT; i++) begin : g_wrap
            iob_cache_wrap_detect u_wrap (
                .clk_i    (clk_i),
                .arst_n_i (arst_n_i),
                .msb_i    (cnt[i][DATA_W-1]),
                .rst_i    (state_q == ST_RST),
                .clr_i    (do_clrw),
                .flag_o   (wrap_flags[i])
            );
        end
    endgenerate

    // ---------------------------------------------------------- read path
    assign total = snap_q[0] + snap_q[1] + snap_q[2] + snap_q[3];

    always_comb begin
        rd_dat = '0;
        if (addr_ok) begin
            case (reg_idx)
                ADDR_SNAP_RH: rd_dat = snap_q[0];
                ADDR_SNAP_RM: rd_dat = snap_q[1];
                ADDR_SNAP_WH: rd_dat = snap_q[2];
                ADDR_SNAP_WM: rd_dat = snap_q[3];
                ADDR_STATUS: begin
                    rd_dat[STAT_WRAP_LSB +: N_CNT] = wrap_flags;
                    rd_dat[STAT_SNAP_VLD]          = snap_vld_q;
                end
                ADDR_TOTAL:   rd_dat = total;
                ADDR_VERSION: rd_dat = DATA_W'(VERSION);
                default:      rd_dat = '0;   // CTRL is write-only
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rsp_rdata_o <= '0;
        end else if (accept) begin
            rsp_rdata_o <= req_wen_i ? '0 : rd_dat;
        end
    end

endmodule

// File: tb/tb_iob_cache_perf_regs.sv
// Purpose: self-checking bench for iob_cache_perf_regs with a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_iob_cache_perf_regs;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [31:0] rh = '0, rm = '0, wh = '0, wm = '0;
    logic        reset_counters;
    logic        req_valid = 1'b0;
    logic [2:0]  req_addr = '0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iob_cache_perf_regs #(.DATA_W(32), .ADDR_W(3), .VERSION(16'h0001)) dut (
        .clk_i            (clk),
        .arst_n_i         (arst_n),
        .read_hit_cnt_i   (rh),
        .read_miss_cnt_i  (rm),
        .write_hit_cnt_i  (wh),
        .write_miss_cnt_i (wm),
        .reset_counters_o (reset_counters),
        .req_valid_i      (req_valid),
        .req_addr_i       (req_addr),
        .req_wen_i        (req_wen),
        .req_wdata_i      (req_wdata),
        .req_ready_o      (req_ready),
        .rsp_valid_o      (rsp_valid),
        .rsp_rdata_o      (rsp_rdata)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------- model
    // Edge k ends slot k-1 and starts slot k; the model records in which
    // slots the clear pulse and the response must appear, and until which
    // slot the port is busy.
    int          cyc = 0;
    int          m_busy = -10, m_rsp_slot = -10, m_rst_slot = -10;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_snap [4];
    logic [31:0] m_prev [4];
    logic [31:0] m_live [4];
    logic        m_snap_vld = 1'b0;
    logic [3:0]  m_flag = '0;
    logic        m_rst_now, m_acc, m_snap_now, m_clr_now, m_wrapped;

    function automatic logic [31:0] m_read(logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return m_snap[a];
            3'd5: return {27'b0, m_snap_vld, m_flag};
            3'd6: return m_snap[0] + m_snap[1] + m_snap[2] + m_snap[3];
            3'd7: return 32'h0000_0001;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        m_live[0] = rh; m_live[1] = rm; m_live[2] = wh; m_live[3] = wm;
        cyc = cyc + 1;
        if (!arst_n) begin
            m_busy = -10; m_rsp_slot = -10; m_rst_slot = -10;
            m_snap_vld = 1'b0; m_flag = '0;
            for (int i = 0; i < 4; i++) begin
                m_snap[i] = '0;
                m_prev[i] = '0;
            end
        end else begin
            m_rst_now  = (cyc - 1 == m_rst_slot);
            m_acc      = req_valid && (cyc - 1 > m_busy);
            m_snap_now = 1'b0;
            m_clr_now  = 1'b0;
            if (m_acc) begin
                if (!req_wen) begin
                    m_rdata    = m_read(req_addr);
                    m_rsp_slot = cyc;
                end else begin
                    m_rdata = '0;
                    if (req_addr == 3'd4) begin
                        m_snap_now = req_wdata[0];
                        m_clr_now  = req_wdata[2];
                    end
                    if (req_addr == 3'd4 && req_wdata[1]) begin
                        m_rst_slot = cyc;
                        m_rsp_slot = cyc + 1;
                    end else begin
                        m_rsp_slot = cyc;
                    end
                end
                m_busy = m_rsp_slot;
            end
            for (int i = 0; i < 4; i++) begin
                m_wrapped = m_prev[i][31] & ~m_live[i][31];
                if (m_rst_now)      m_flag[i] = 1'b0;
                else if (m_wrapped) m_flag[i] = 1'b1;
                else if (m_clr_now) m_flag[i] = 1'b0;
                m_prev[i] = m_rst_now ? 32'h0 : m_live[i];
            end
            if (m_snap_now) begin
                for (int i = 0; i < 4; i++) m_snap[i] = m_live[i];
                m_snap_vld = 1'b1;
            end
        end
    end

    // ----------------------------------------------------- cycle compare
    always @(negedge clk) begin
        if (!arst_n) begin
            chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
            chk("reset_rst_pulse", {31'b0, reset_counters}, 32'd0);
            chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("reset_rdata", rsp_rdata, 32'd0);
        end else begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, cyc > m_busy});
            chk("reset_counters", {31'b0, reset_counters}, {31'b0, cyc == m_rst_slot});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, cyc == m_rsp_slot});
            if (cyc == m_rsp_slot) chk("rsp_rdata", rsp_rdata, m_rdata);
        end
    end

    // ------------------------------------------------------ stimulus
    // Tasks start and end at posedge+1.
    task automatic req(input logic wen, input logic [2:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        logic r;
        logic got;
        int   n;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd;
        r = 1'b0; n = 0;
        while (!r && n < 20) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            n++;
        end
        if (!r) chk("accept_timeout", 32'd0, 32'd1);
        #1 req_valid = 1'b0;
        lat = 0; got = 1'b0; rd = '0;
        while (!got && lat < 5) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1'b1;
                rd  = rsp_rdata;
            end
        end
        if (!got) chk("response_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input logic [2:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        int          lat;
        req(1'b0, addr, 32'h0, rd, lat);
        chk(name, rd, exp);
        chk({name, "_latency"}, lat, 32'd1);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wd, input int exp_lat, input string name);
        logic [31:0] rd;
        int          lat;
        req(1'b1, addr, wd, rd, lat);
        chk({name, "_rdata"}, rd, 32'd0);
        chk({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    int n_acc, n_rsp;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #2 arst_n = 1'b1;
        step();

        rd_chk(3'd5, 32'h0, "status_after_reset");
        rd_chk(3'd7, 32'h1, "version");

        // Snapshot of 5/3/7/1
        rh = 5; rm = 3; wh = 7; wm = 1;
        wr(3'd4, 32'h1, 1, "ctrl_snap");
        rd_chk(3'd0, 32'd5, "snap_rh");
        rd_chk(3'd1, 32'd3, "snap_rm");
        rd_chk(3'd2, 32'd7, "snap_wh");
        rd_chk(3'd3, 32'd1, "snap_wm");
        rd_chk(3'd6, 32'd16, "total_16");
        rd_chk(3'd5, 32'h10, "status_snap_valid");
        rd_chk(3'd4, 32'h0, "ctrl_reads_zero");
        wr(3'd0, 32'hDEAD, 1, "write_ro");
        rd_chk(3'd0, 32'd5, "ro_unchanged");

        // SNAP + RST_CNT: snapshot keeps pre-clear value
        rh = 9;
        wr(3'd4, 32'h3, 2, "ctrl_snap_rst");
        rh = 0; rm = 0; wh = 0; wm = 0;   // counter block cleared
        step();
        rd_chk(3'd0, 32'd9, "snap_rh_pre_reset");
        rd_chk(3'd5, 32'h10, "no_wrap_on_clear");

        // Read-miss wrap then CLR_WRAP
        rm = 32'hFFFF_FFFF; step();
        rm = 32'h0; step();
        rd_chk(3'd5, 32'h12, "status_rm_wrap");
        wr(3'd4, 32'h4, 1, "ctrl_clr_wrap");
        rd_chk(3'd5, 32'h10, "status_cleared");

        // Wrap coincident with CLR_WRAP accept: wrap wins
        wh = 32'h8000_0000; step(); step();
        wh = 32'h0;
        wr(3'd4, 32'h4, 1, "ctrl_clr_vs_wrap");
        rd_chk(3'd5, 32'h14, "wrap_beats_clear");
        wr(3'd4, 32'h4, 1, "ctrl_clr_wrap2");

        // TOTAL wraps mod 2^32
        rh = 32'hFFFF_FFFF; rm = 1; wh = 0; wm = 0;
        wr(3'd4, 32'h1, 1, "ctrl_snap2");
        rd_chk(3'd6, 32'h0, "total_mod");
        rd_chk(3'd0, 32'hFFFF_FFFF, "snap_rh_max");
        rh = 0; rm = 0; step();
        rd_chk(3'd5, 32'h11, "status_rh_wrap");

        // Back-to-back requests held valid
        n_acc = 0; n_rsp = 0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 3'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready) n_acc++;
            if (rsp_valid) n_rsp++;
        end
        @(posedge clk); #1 req_valid = 1'b0;
        chk("b2b_accepts", n_acc, 32'd5);
        chk("b2b_responses", n_rsp, 32'd5);
        step(); step();

        // Reset asserted during the RST cycle
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 3'd4; req_wdata = 32'h2;
        @(posedge clk); #1 req_valid = 1'b0;
        #1 chk("rst_pulse_high", {31'b0, reset_counters}, 32'd1);
        arst_n = 1'b0;
        #1 chk("rst_pulse_dropped", {31'b0, reset_counters}, 32'd0);
        chk("ready_after_async_reset", {31'b0, req_ready}, 32'd1);
        chk("no_rsp_after_async_reset", {31'b0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 arst_n = 1'b1;
        step(); step();
        rd_chk(3'd5, 32'h0, "status_after_midreset");
        rd_chk(3'd0, 32'h0, "snap_after_midreset");
        rd_chk(3'd7, 32'h1, "version_final");

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
